// File: rtl/rho_pkg.sv
// rho_pkg: shared constants, rho offsets and state encoding for the rho stage
package rho_pkg;
    localparam int SLICES = 64;
    localparam int ADR_W = 6;
    localparam int LANES = 25;
    localparam logic [ADR_W-1:0] R [LANES] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
endpackage

// File: rtl/rho_lane_buffer.sv
// rho_lane_buffer: 25 lane registers written by slice, read back as a rho-rotated slice
module rho_lane_buffer
    import rho_pkg::*;
(
    input  logic             clock,
    input  logic             we,
    input  logic [ADR_W-1:0] wadr,
    input  logic [LANES-1:0] wdata,
    input  logic [ADR_W-1:0] radr,
    output logic [LANES-1:0] rdata
);
    logic [SLICES-1:0] lane [LANES];
    logic [ADR_W-1:0] idx [LANES];
    always_ff @(posedge clock)
        if (we)
            for (int l = 0; l < LANES; l++)
                lane[l][wadr] <= wdata[l];
    // 6-bit subtraction wraps naturally across slice 0/63
    for (genvar l = 0; l < LANES; l++) begin : g_rd
        assign idx[l] = radr - R[l];
        assign rdata[l] = lane[l][idx[l]];
    end
endmodule

// File: rtl/rho_slice_rotator.sv
// rho_slice_rotator: loads the theta result, writes back each slice with lanes rotated by rho
module rho_slice_rotator
    import rho_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LANES-1:0] in,
    output logic             done,
    output logic [ADR_W-1:0] mem_adr,
    output logic [LANES-1:0] mem_in,
    output logic             mem_r,
    output logic             mem_w
);
    state_t state;
    logic [ADR_W-1:0] counter;
    logic [LANES-1:0] rot;
    rho_lane_buffer u_buf (
        .clock(clock),
        .we(mem_r),
        .wadr(counter),
        .wdata(in),
        .radr(counter),
        .rdata(rot)
    );
    // counter wraps to 0 at the end of each phase, so the address idles at 0
    assign mem_adr = counter;
    assign mem_in = mem_w ? rot : '0;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            counter <= '0;
            done <= 1'b0;
            mem_r <= 1'b0;
            mem_w <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    counter <= '0;
                    mem_r <= 1'b1;
                end
                LOAD: begin
                    counter <= counter + 6'd1;
                    if (&counter) begin
                        state <= STORE;
                        mem_r <= 1'b0;
                        mem_w <= 1'b1;
                    end
                end
                STORE: begin
                    counter <= counter + 6'd1;
                    if (&counter) begin
                        state <= DONE;
                        mem_w <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: if (!start) begin
                    state <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_rho_slice_rotator.sv
// tb_rho_slice_rotator: directed and random rho runs against a lane-rotation model
module tb_rho_slice_rotator;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [24:0] in_data;
    logic done, mem_r, mem_w;
    logic [5:0] mem_adr;
    logic [24:0] mem_in;
    logic [24:0] mem [64];
    logic [24:0] img [64];
    logic [24:0] exp_mem [64];
    logic load_req = 1'b0;
    logic chk_en = 1'b0;
    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int offs [25] = '{0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14};

    rho_slice_rotator dut (
        .clock(clock), .reset(reset), .start(start), .in(in_data),
        .done(done), .mem_adr(mem_adr), .mem_in(mem_in), .mem_r(mem_r), .mem_w(mem_w)
    );

    always #5 clock = ~clock;
    assign in_data = mem_r ? mem[mem_adr] : '0;

    always @(posedge clock)
        if (load_req)
            for (int z = 0; z < 64; z++) mem[z] <= img[z];
        else if (mem_w)
            mem[mem_adr] <= mem_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (mem_r) rd_cnt++;
        if (mem_w) wr_cnt++;
        if (reset) check("rw_overlap", {62'd0, mem_r, mem_w} == 64'd3, 64'd0);
        if (chk_en && mem_w) check("stream_word", {39'd0, mem_in}, {39'd0, exp_mem[mem_adr]});
    end

    // rotate each 64-bit lane left by its offset: slice s moves to s+R
    task automatic build_model();
        logic [63:0] lane, rot;
        for (int z = 0; z < 64; z++) exp_mem[z] = '0;
        for (int i = 0; i < 25; i++) begin
            for (int z = 0; z < 64; z++) lane[z] = img[z][i];
            rot = (offs[i] == 0) ? lane : (lane << offs[i]) | (lane >> (64 - offs[i]));
            for (int z = 0; z < 64; z++) exp_mem[z][i] = rot[z];
        end
    endtask

    task automatic load_img();
        build_model();
        load_req = 1'b1;
        @(posedge clock);
        #1 load_req = 1'b0;
    endtask

    task automatic run_and_check(input string name);
        int edges, bad;
        load_img();
        rd_cnt = 0;
        wr_cnt = 0;
        chk_en = 1'b1;
        start = 1'b1;
        edges = 0;
        while (!done && edges < 300) begin
            @(posedge clock);
            edges++;
            #1;
        end
        check({name, "_done_edge"}, 64'(edges), 64'd129);
        check({name, "_reads"}, 64'(rd_cnt), 64'd64);
        check({name, "_writes"}, 64'(wr_cnt), 64'd64);
        bad = 0;
        for (int z = 0; z < 64; z++) if (mem[z] !== exp_mem[z]) bad++;
        check({name, "_bad_words"}, 64'(bad), 64'd0);
        repeat (4) @(posedge clock);
        #1;
        check({name, "_hold_done"}, {63'd0, done}, 64'd1);
        check({name, "_hold_access"}, 64'(rd_cnt + wr_cnt), 64'd128);
        start = 1'b0;
        @(posedge clock);
        #1;
        check({name, "_done_clear"}, {63'd0, done}, 64'd0);
        chk_en = 1'b0;
    endtask

    task automatic clear_img();
        for (int z = 0; z < 64; z++) img[z] = '0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_r", {63'd0, mem_r}, 64'd0);
        check("rst_w", {63'd0, mem_w}, 64'd0);
        check("rst_adr", {58'd0, mem_adr}, 64'd0);
        check("rst_in", {39'd0, mem_in}, 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        clear_img();
        img[0] = 25'h0000002;
        run_and_check("bit1");
        check("bit1_s1", {39'd0, mem[1]}, 64'h2);
        check("bit1_s0", {39'd0, mem[0]}, 64'h0);

        clear_img();
        img[5] = 25'h0000005;
        run_and_check("s5");
        check("s5_s3", {39'd0, mem[3]}, 64'h4);
        check("s5_s5", {39'd0, mem[5]}, 64'h1);

        clear_img();
        img[60] = 25'h1000000;
        img[63] = 25'h0400000;
        run_and_check("wrap");
        check("wrap_s10", {39'd0, mem[10]}, 64'h1000000);
        check("wrap_s60", {39'd0, mem[60]}, 64'h0400000);
        check("wrap_s63", {39'd0, mem[63]}, 64'h0);

        for (int z = 0; z < 64; z++) img[z] = 25'h1FFFFFF;
        run_and_check("ones");
        check("ones_s17", {39'd0, mem[17]}, 64'h1FFFFFF);

        for (int z = 0; z < 64; z++) img[z] = 25'($urandom);
        run_and_check("rand");

        for (int z = 0; z < 64; z++) img[z] = 25'($urandom);
        load_img();
        chk_en = 1'b1;
        start = 1'b1;
        repeat (70) @(posedge clock);
        #1;
        check("mid_w_before", {63'd0, mem_w}, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_w_after", {63'd0, mem_w}, 64'd0);
        check("mid_done", {63'd0, done}, 64'd0);
        check("mid_r", {63'd0, mem_r}, 64'd0);
        chk_en = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        run_and_check("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
